// File: rtl/riscv_v_bw_wb_stage.sv
// riscv_v_bw_wb_stage: reduction-aware writeback register with 2-entry skid FIFO; RISCV_V_BW_WB_PARITY_EN adds per-byte parity
module riscv_v_bw_wb_stage #(
    parameter int NUM_BYTES  = 16,
    parameter int BYTE_WIDTH = 8,
    parameter int ADDR_W     = 5
) (
    input  logic                            clk,
    input  logic                            rst_n,
    input  logic                            in_valid,
    output logic                            in_ready,
    input  logic [NUM_BYTES*BYTE_WIDTH-1:0] in_result,
    input  logic [NUM_BYTES-1:0]            in_byte_valid,
    input  logic                            in_is_reduct,
    input  logic [1:0]                      in_osize,
    input  logic [ADDR_W-1:0]               in_vd,
    output logic                            out_valid,
    input  logic                            out_ready,
    output logic [NUM_BYTES*BYTE_WIDTH-1:0] out_data,
    output logic [NUM_BYTES-1:0]            out_byte_we,
    output logic [ADDR_W-1:0]               out_vd,
    output logic                            out_is_reduct
`ifdef RISCV_V_BW_WB_PARITY_EN
    ,
    output logic [NUM_BYTES-1:0]            out_parity
`endif
);
    typedef struct packed {
        logic [NUM_BYTES*BYTE_WIDTH-1:0] data;
        logic [NUM_BYTES-1:0]            we;
        logic [ADDR_W-1:0]               vd;
        logic                            red;
`ifdef RISCV_V_BW_WB_PARITY_EN
        logic [NUM_BYTES-1:0]            par;
`endif
    } entry_t;

    typedef enum logic [1:0] {EMPTY, ONE, FULL} state_t;

    state_t state, state_nx;
    entry_t head, tail, fmt;
    logic   in_xfer, out_xfer;
    int     e, idx;

    assign in_xfer  = in_valid & in_ready;
    assign out_xfer = out_valid & out_ready;

    // Reductions leave the final element in the top slot; move it to element 0.
    always_comb begin
        fmt = '0;
        idx = 0;
        e   = 1 << in_osize;
        e   = (e > NUM_BYTES) ? NUM_BYTES : e;
        fmt.vd  = in_vd;
        fmt.red = in_is_reduct;
        for (int i = 0; i < NUM_BYTES; i++) begin
            idx = (i < e) ? NUM_BYTES - e + i : i;
            fmt.data[i*BYTE_WIDTH +: BYTE_WIDTH] = !in_is_reduct ? in_result[i*BYTE_WIDTH +: BYTE_WIDTH] :
                (i < e) ? in_result[idx*BYTE_WIDTH +: BYTE_WIDTH] : '0;
            fmt.we[i] = in_is_reduct ? (i < e) : in_byte_valid[i];
`ifdef RISCV_V_BW_WB_PARITY_EN
            fmt.par[i] = ^fmt.data[i*BYTE_WIDTH +: BYTE_WIDTH];
`endif
        end
    end

    always_comb begin
        state_nx = state == EMPTY ? (in_xfer ? ONE : EMPTY) :
                   state == ONE   ? ((in_xfer && !out_xfer) ? FULL : (!in_xfer && out_xfer) ? EMPTY : ONE) :
                                    (out_xfer ? ONE : FULL);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= EMPTY;
            head     <= '0;
            tail     <= '0;
            in_ready <= 1'b1;
        end else begin
            if (in_xfer && (state == EMPTY || (state == ONE && out_xfer)))
                head <= fmt;
            else if (state == FULL && out_xfer)
                head <= tail;
            if (in_xfer && state == ONE && !out_xfer)
                tail <= fmt;
            state    <= state_nx;
            in_ready <= state_nx != FULL;
        end
    end

    assign out_valid     = state != EMPTY;
    assign out_data      = head.data;
    assign out_byte_we   = head.we;
    assign out_vd        = head.vd;
    assign out_is_reduct = head.red;
`ifdef RISCV_V_BW_WB_PARITY_EN
    assign out_parity    = head.par;
`endif
endmodule
